// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO, configurable data width, parity and stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input and the BREAK/guard states.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef UART_TX_BREAK_EN
    input  logic                              tx_break,
`endif
    input  logic [DATA_BITS-1:0]              tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              txd,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW           = $clog2(FIFO_DEPTH + 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be 5..9");
        end
        if (PARITY > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_baud
            $error("uart_tx_fifo: BAUD must not exceed CLK_FREQ");
        end
    endgenerate

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreak, StGuard
    } state_t;
`else
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop
    } state_t;
`endif

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] head;

    logic push;
    logic pop;
    logic baud_end;
    logic data_last;
    logic stop_last;
    logic break_req;

`ifdef UART_TX_BREAK_EN
    assign break_req = tx_break;
`else
    assign break_req = 1'b0;
`endif

    assign tx_ready  = (fifo_count != CW'(FIFO_DEPTH));
    assign push      = tx_valid && tx_ready;
    assign head      = mem[rd_ptr];
    assign baud_end  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign data_last = (bit_cnt == 4'(DATA_BITS - 1));
    assign stop_last = (bit_cnt == 4'(STOP_BITS - 1));

    // A pending break always wins over starting the next frame.
    always_comb begin
        pop = 1'b0;
        if (fifo_count != '0 && !break_req) begin
            case (state)
                StIdle:  pop = 1'b1;
                StStop:  pop = baud_end && stop_last;
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else if (pop) begin
            // Start bit goes out on the same edge the head entry is taken.
            state    <= StStart;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= head;
            par_bit  <= (PARITY == 1) ? ~^head : ^head;
            txd      <= 1'b0;
            tx_busy  <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        state   <= StBreak;
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                    end
`endif
                end
                StStart: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shreg[0];
                        shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
                        state    <= StData;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (data_last) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= StParity;
                                txd   <= par_bit;
                            end else begin
                                state <= StStop;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                StParity: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= StStop;
                        txd      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (stop_last) begin
                            bit_cnt <= '0;
`ifdef UART_TX_BREAK_EN
                            if (break_req) begin
                                state <= StBreak;
                                txd   <= 1'b0;
                            end else begin
                                state   <= StIdle;
                                tx_busy <= 1'b0;
                            end
`else
                            state   <= StIdle;
                            tx_busy <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_BREAK_EN
                StBreak: begin
                    baud_cnt <= '0;
                    if (!break_req) begin
                        state <= StGuard;
                        txd   <= 1'b1;
                    end
                end
                StGuard: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= StIdle;
                        tx_busy  <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state   <= StIdle;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: an 8N1 instance plus even- and odd-parity instances.
// Serial monitors decode txd at mid-bit and compare against expected frames queued at push time.
module tb_uart_tx_fifo;

    localparam int CPB   = 104;
    localparam int LIMIT = 5000;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data_p = 8'h00;
    logic       tx_valid_p = 1'b0;
    logic       tx_break = 1'b0;

    logic       tx_ready0, txd0, busy0;
    logic [2:0] count0;
    logic       tx_ready1, txd1, busy1;
    logic [2:0] count1;
    logic       tx_ready2, txd2, busy2;
    logic [2:0] count2;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   abort_f [3];
    bit   brk_active = 1'b0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    int   falls[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge rst) for (int i = 0; i < 3; i++) abort_f[i] = 1'b1;

    uart_tx_fifo u_dut (
        .clk        (clk),
        .rst        (rst),
`ifdef UART_TX_BREAK_EN
        .tx_break   (tx_break),
`endif
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready0),
        .txd        (txd0),
        .tx_busy    (busy0),
        .fifo_count (count0)
    );

    uart_tx_fifo #(.PARITY(2)) u_even (
        .clk        (clk),
        .rst        (rst),
`ifdef UART_TX_BREAK_EN
        .tx_break   (1'b0),
`endif
        .tx_data    (tx_data_p),
        .tx_valid   (tx_valid_p),
        .tx_ready   (tx_ready1),
        .txd        (txd1),
        .tx_busy    (busy1),
        .fifo_count (count1)
    );

    uart_tx_fifo #(.PARITY(1)) u_odd (
        .clk        (clk),
        .rst        (rst),
`ifdef UART_TX_BREAK_EN
        .tx_break   (1'b0),
`endif
        .tx_data    (tx_data_p),
        .tx_valid   (tx_valid_p),
        .tx_ready   (tx_ready2),
        .txd        (txd2),
        .tx_busy    (busy2),
        .fifo_count (count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic line(input int w);
        case (w)
            0:       return txd0;
            1:       return txd1;
            default: return txd2;
        endcase
    endfunction

    function automatic int sb_size(input int w);
        case (w)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int w);
        case (w)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    task automatic wait_n(input int w, input int n);
        for (int k = 0; k < n; k++) begin
            if (abort_f[w]) break;
            @(negedge clk);
        end
    endtask

    // Instance 0 is 8N1; instances 1 and 2 carry a parity bit.
    task automatic monitor(input int w);
        logic [7:0] d;
        logic       p;
        logic       ok;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst && !brk_active && line(w) == 1'b0) begin
                abort_f[w] = 1'b0;
                if (w == 0) falls.push_back(cyc);
                wait_n(w, CPB / 2);
                ok = (line(w) == 1'b0);
                d  = '0;
                for (int i = 0; i < 8; i++) begin
                    wait_n(w, CPB);
                    d[i] = line(w);
                end
                p = 1'b0;
                if (w != 0) begin
                    wait_n(w, CPB);
                    p = line(w);
                end
                wait_n(w, CPB);
                ok = ok && (line(w) == 1'b1);
                if (!abort_f[w]) begin
                    if (sb_size(w) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected%0d: got frame 0x%0h, required no frame", w, d);
                    end else begin
                        e = sb_pop(w);
                        check($sformatf("rx_data%0d", w), 32'(d), 32'(e.d));
                        if (w != 0) check($sformatf("rx_parity%0d", w), 32'(p), 32'(e.p));
                        check($sformatf("rx_framing%0d", w), 32'(ok), 32'd1);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic push(input logic [7:0] b);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(tx_ready0), 32'd1);
        sb0.push_back('{d: b, p: 1'b0});
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic push_p(input logic [7:0] b, input logic pe, input logic po);
        tx_data_p  = b;
        tx_valid_p = 1'b1;
        sb1.push_back('{d: b, p: pe});
        sb2.push_back('{d: b, p: po});
        @(negedge clk);
        tx_valid_p = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb0.size() + sb1.size() + sb2.size() != 0 || busy0 || busy1 || busy2)
               && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(sb0.size() + sb1.size() + sb2.size()), 32'd0);
    endtask

    initial begin
        int n;
        int m;
        int t_end;
        int lows;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd0), 32'd1);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_ready", 32'(tx_ready0), 32'd1);
        check("reset_count", 32'(count0), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single 8N1 frame: latency and total busy time.
        push(8'h42);
        check("latency_edge_n_txd", 32'(txd0), 32'd1);
        check("latency_edge_n_count", 32'(count0), 32'd1);
        @(negedge clk);
        check("latency_edge_n1_txd", 32'(txd0), 32'd0);
        check("latency_edge_n1_busy", 32'(busy0), 32'd1);
        check("latency_edge_n1_count", 32'(count0), 32'd0);
        m = 0;
        while (busy0 && m < 3000) begin
            @(negedge clk);
            m++;
        end
        check("frame_len_8n1", 32'(m), 32'd1040);
        drain();

        // Parity: 0x42 has two ones, 0x07 has three.
        push_p(8'h42, 1'b0, 1'b1);
        n = 0;
        while (txd1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        m = 0;
        while (busy1 && m < 3000) begin
            @(negedge clk);
            m++;
        end
        check("frame_len_8e1", 32'(m), 32'd1144);
        repeat (5) @(negedge clk);
        push_p(8'h07, 1'b1, 1'b0);
        drain();

        // Burst of six into a depth-4 FIFO with tx_valid held.
        falls.delete();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        check("burst_full_count", 32'(count0), 32'd4);
        check("burst_full_ready", 32'(tx_ready0), 32'd0);
        push(8'h66);
        drain();
        check("burst_frames", 32'(falls.size()), 32'd6);
        for (int k = 0; k + 1 < falls.size(); k++) begin
            check($sformatf("burst_gap%0d", k), 32'(falls[k+1] - falls[k]), 32'd1040);
        end

        // Reset in the middle of data bit 3 (a 0 bit of 0x62) with two bytes queued.
        repeat (5) @(negedge clk);
        push(8'h62);
        n = 0;
        while (txd0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        push(8'h11);
        push(8'h99);
        repeat (4 * CPB + 40 - 2) @(negedge clk);
        #1 rst = 1'b1;
        sb0.delete();
        #1;
        check("midrst_txd", 32'(txd0), 32'd1);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_count", 32'(count0), 32'd0);
        check("midrst_ready", 32'(tx_ready0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_txd", 32'(txd0), 32'd1);
        push(8'hA5);
        drain();

`ifdef UART_TX_BREAK_EN
        // 500-cycle break from IDLE with a byte queued midway.
        repeat (5) @(negedge clk);
        falls.delete();
        brk_active = 1'b1;
        tx_break   = 1'b1;
        lows       = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (txd0 == 1'b0) lows++;
            tx_data  = 8'h81;
            tx_valid = (k == 200);
            if (k == 200) sb0.push_back('{d: 8'h81, p: 1'b0});
        end
        tx_valid = 1'b0;
        check("break_low_cycles", 32'(lows), 32'd500);
        check("break_no_pop", 32'(count0), 32'd1);
        check("break_busy", 32'(busy0), 32'd1);
        tx_break = 1'b0;
        n = 0;
        lows = 0;
        while (busy0 && n < 1000) begin
            @(negedge clk);
            n++;
            if (busy0 && txd0 == 1'b0) lows++;
        end
        // One edge to sample the deassertion, then the guard period.
        check("guard_len", 32'(n), 32'(CPB + 1));
        check("guard_txd_high", 32'(lows), 32'd0);
        t_end = cyc;
        brk_active = 1'b0;
        n = 0;
        while (falls.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("after_guard_start", 32'(falls.size() > 0 ? falls[0] - t_end : -1), 32'd1);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
